// File: rtl/gsu_cache_if.sv
// Fetch and ROM handshake bundle between the GSU fetch stage, the
// instruction cache and the Game Pak ROM arbiter.
interface gsu_cache_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic        fetch_hit;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;

    // Core / ROM side: issues fetches and answers ROM reads.
    modport master (
        output fetch_req, fetch_addr, rom_ack, rom_data,
        input  fetch_ack, fetch_data, fetch_hit, rom_req, rom_addr
    );

    // Cache side: serves fetches and requests ROM bytes.
    modport slave (
        input  fetch_req, fetch_addr, rom_ack, rom_data,
        output fetch_ack, fetch_data, fetch_hit, rom_req, rom_addr
    );
endinterface

// File: rtl/gsu_cache.sv
// GSU instruction cache: CBR-windowed cache RAM with per-line valid flags,
// line fill from ROM on a miss, uncached bypass outside the window and a
// host port for direct RAM access. All outputs are registered.
module gsu_cache #(
    parameter int LINE_W = 4,
    parameter int IDX_W  = 5
) (
    input  logic                    clkin,
    input  logic                    rst_n,
    gsu_cache_if.slave              bus,
    input  logic                    cbr_load,
    input  logic [15:0]             cbr_in,
    output logic [15:0]             cbr,
    output logic                    busy,
    input  logic                    host_we,
    input  logic [IDX_W+LINE_W-1:0] host_addr,
    input  logic [7:0]              host_di,
    output logic [7:0]              host_do,
    output logic [(1<<IDX_W)-1:0]   valid_flags
);
    localparam int CS_W = IDX_W + LINE_W;
    localparam int CS   = 1 << CS_W;
    localparam int NL   = 1 << IDX_W;
    localparam logic [15:0] LINE_MASK = ~((16'd1 << LINE_W) - 16'd1);

    typedef enum logic [1:0] {IDLE, HIT, FILL, BYPASS} state_t;

    // Clears the byte-within-line bits of an address.
    function automatic logic [15:0] line_align(input logic [15:0] a);
        return a & LINE_MASK;
    endfunction

    logic [7:0]        ram_r [CS];
    state_t            state_r, state_s;
    logic [15:0]       cbr_r, cbr_s;
    logic [NL-1:0]     flags_r, flags_s;
    logic              ack_r, ack_s, hit_r, hit_s, busy_r, busy_s;
    logic [7:0]        data_r, data_s, byte_r, byte_s, host_do_r, host_do_s;
    logic              rom_req_r, rom_req_s, pend_r, pend_s;
    logic [15:0]       rom_addr_r, rom_addr_s, pend_cbr_r, pend_cbr_s;
    logic [CS_W-1:0]   idx_r, idx_s, ram_waddr_s;
    logic [LINE_W-1:0] k_r, k_s;
    logic              ram_we_s, in_win_s;
    logic [7:0]        ram_wdata_s;
    logic [15:0]       off_s;

    // Next-state and next-output logic for the fetch FSM, flags and CBR.
    always_comb begin
        state_s     = state_r;
        cbr_s       = cbr_r;
        flags_s     = flags_r;
        ack_s       = 1'b0;
        hit_s       = 1'b0;
        data_s      = data_r;
        byte_s      = byte_r;
        rom_req_s   = rom_req_r;
        rom_addr_s  = rom_addr_r;
        pend_s      = pend_r;
        pend_cbr_s  = pend_cbr_r;
        idx_s       = idx_r;
        k_s         = k_r;
        ram_we_s    = 1'b0;
        ram_waddr_s = host_addr;
        ram_wdata_s = host_di;
        off_s       = bus.fetch_addr - cbr_r;
        in_win_s    = ((off_s >> CS_W) == 16'd0);
        host_do_s   = ram_r[host_addr];

        case (state_r)
            IDLE: begin
                // A flush (new or deferred) takes the cycle; the fetch waits.
                if (cbr_load) begin
                    cbr_s   = line_align(cbr_in);
                    flags_s = '0;
                    pend_s  = 1'b0;
                end else if (pend_r) begin
                    cbr_s   = pend_cbr_r;
                    flags_s = '0;
                    pend_s  = 1'b0;
                end else if (bus.fetch_req) begin
                    idx_s = off_s[CS_W-1:0];
                    k_s   = '0;
                    if (!in_win_s) begin
                        state_s    = BYPASS;
                        rom_req_s  = 1'b1;
                        rom_addr_s = bus.fetch_addr;
                    end else if (flags_r[off_s[CS_W-1:LINE_W]]) begin
                        state_s = HIT;
                    end else begin
                        state_s    = FILL;
                        rom_req_s  = 1'b1;
                        rom_addr_s = cbr_r + line_align(off_s);
                    end
                end else begin
                    state_s = IDLE;
                end
                // Host write lands after any flush so its flag set wins.
                if (host_we) begin
                    ram_we_s = 1'b1;
                    if (&host_addr[LINE_W-1:0]) begin
                        flags_s[host_addr[CS_W-1:LINE_W]] = 1'b1;
                    end else begin
                        flags_s = flags_s;
                    end
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            HIT: begin
                data_s  = ram_r[idx_r];
                ack_s   = 1'b1;
                hit_s   = 1'b1;
                state_s = IDLE;
            end
            FILL: begin
                if (bus.rom_ack) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = {idx_r[CS_W-1:LINE_W], k_r};
                    ram_wdata_s = bus.rom_data;
                    if (k_r == idx_r[LINE_W-1:0]) begin
                        byte_s = bus.rom_data;
                    end else begin
                        byte_s = byte_r;
                    end
                    if (&k_r) begin
                        flags_s[idx_r[CS_W-1:LINE_W]] = 1'b1;
                        rom_req_s = 1'b0;
                        ack_s     = 1'b1;
                        data_s    = (k_r == idx_r[LINE_W-1:0]) ? bus.rom_data : byte_r;
                        state_s   = IDLE;
                    end else begin
                        k_s        = k_r + LINE_W'(1);
                        rom_addr_s = rom_addr_r + 16'd1;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            BYPASS: begin
                if (bus.rom_ack) begin
                    data_s    = bus.rom_data;
                    ack_s     = 1'b1;
                    rom_req_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s = BYPASS;
                end
            end
            default: begin
                state_s   = IDLE;
                rom_req_s = 1'b0;
            end
        endcase

        // A CBR load while a fetch is in flight is deferred; last one wins.
        if (cbr_load && (state_r != IDLE)) begin
            pend_s     = 1'b1;
            pend_cbr_s = line_align(cbr_in);
        end else begin
            pend_s = pend_s;
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cbr_r      <= 16'd0;
            flags_r    <= '0;
            ack_r      <= 1'b0;
            hit_r      <= 1'b0;
            data_r     <= 8'd0;
            byte_r     <= 8'd0;
            rom_req_r  <= 1'b0;
            rom_addr_r <= 16'd0;
            pend_r     <= 1'b0;
            pend_cbr_r <= 16'd0;
            idx_r      <= '0;
            k_r        <= '0;
            busy_r     <= 1'b0;
            host_do_r  <= 8'd0;
        end else begin
            state_r    <= state_s;
            cbr_r      <= cbr_s;
            flags_r    <= flags_s;
            ack_r      <= ack_s;
            hit_r      <= hit_s;
            data_r     <= data_s;
            byte_r     <= byte_s;
            rom_req_r  <= rom_req_s;
            rom_addr_r <= rom_addr_s;
            pend_r     <= pend_s;
            pend_cbr_r <= pend_cbr_s;
            idx_r      <= idx_s;
            k_r        <= k_s;
            busy_r     <= busy_s;
            host_do_r  <= host_do_s;
        end
    end

    // Cache RAM write port shared by line fill and host writes.
    always_ff @(posedge clkin) begin
        if (ram_we_s) begin
            ram_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    assign bus.fetch_ack  = ack_r;
    assign bus.fetch_hit  = hit_r;
    assign bus.fetch_data = data_r;
    assign bus.rom_req    = rom_req_r;
    assign bus.rom_addr   = rom_addr_r;
    assign cbr            = cbr_r;
    assign busy           = busy_r;
    assign host_do        = host_do_r;
    assign valid_flags    = flags_r;
endmodule

// File: tb/tb_gsu_cache.sv
// Self-checking bench for gsu_cache: a behavioural cache model predicts
// each fetch result and ROM address sequence into scoreboard queues which
// are checked as the DUT acknowledges fetches and requests ROM bytes.
module tb_gsu_cache;
    localparam int LINE_W = 4;
    localparam int IDX_W  = 5;
    localparam int CS     = 512;

    logic        clk;
    logic        rst_n;
    logic        cbr_load;
    logic [15:0] cbr_in;
    logic [15:0] cbr;
    logic        busy;
    logic        host_we;
    logic [8:0]  host_addr;
    logic [7:0]  host_di;
    logic [7:0]  host_do;
    logic [31:0] valid_flags;

    gsu_cache_if bus();

    gsu_cache #(.LINE_W(LINE_W), .IDX_W(IDX_W)) dut (
        .clkin(clk), .rst_n(rst_n), .bus(bus),
        .cbr_load(cbr_load), .cbr_in(cbr_in), .cbr(cbr), .busy(busy),
        .host_we(host_we), .host_addr(host_addr), .host_di(host_di),
        .host_do(host_do), .valid_flags(valid_flags)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       hit;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rom_q[$];
    logic [7:0]  ram_m [CS];
    logic [31:0] flags_m;
    logic [15:0] cbr_m;
    int          ack_cnt;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Model: predict fetch outcome, ROM reads, RAM and flag updates.
    task automatic predict(input logic [15:0] addr);
        logic [15:0] off;
        logic [15:0] base;
        logic [4:0]  line;
        off  = addr - cbr_m;
        line = off[8:4];
        if (off < 16'd512) begin
            if (flags_m[line]) begin
                exp_q.push_back({ram_m[off[8:0]], 1'b1});
            end else begin
                base = cbr_m + {off[15:4], 4'h0};
                for (int k = 0; k < 16; k++) begin
                    rom_q.push_back(base + 16'(k));
                    ram_m[{line, 4'(k)}] = rom_byte(base + 16'(k));
                end
                flags_m[line] = 1'b1;
                exp_q.push_back({rom_byte(addr), 1'b0});
            end
        end else begin
            rom_q.push_back(addr);
            exp_q.push_back({rom_byte(addr), 1'b0});
        end
    endtask

    task automatic do_fetch(input logic [15:0] addr, output int lat);
        predict(addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (bus.fetch_ack) break;
        end
        if (!bus.fetch_ack) check("fetch_timeout", 32'd0, 32'd1);
        bus.fetch_req = 1'b0;
    endtask

    task automatic load_cbr(input logic [15:0] v);
        cbr_load = 1'b1;
        cbr_in   = v;
        @(posedge clk); #1;
        cbr_load = 1'b0;
        cbr_m    = v & 16'hFFF0;
        flags_m  = 32'd0;
        check("cbr_load", cbr, cbr_m);
        check("cbr_load_flags", valid_flags, 32'd0);
    endtask

    task automatic host_write(input logic [8:0] a, input logic [7:0] d, input logic applies);
        host_we   = 1'b1;
        host_addr = a;
        host_di   = d;
        @(posedge clk); #1;
        host_we = 1'b0;
        if (applies) begin
            ram_m[a] = d;
            if (a[3:0] == 4'hF) flags_m[a[8:4]] = 1'b1;
        end
    endtask

    task automatic host_read(input logic [8:0] a);
        host_addr = a;
        @(posedge clk); #1;
        check("host_do", host_do, ram_m[a]);
    endtask

    task automatic wait_acks(input int target);
        int t;
        t = 0;
        while (ack_cnt < target && t < 500) begin
            @(posedge clk); #2;
            t++;
        end
        check("wait_acks", ack_cnt >= target, 32'd1);
    endtask

    // ROM responder: random-gap acks, checks each ROM address.
    initial begin
        bus.rom_ack  = 1'b0;
        bus.rom_data = 8'd0;
        forever begin
            @(posedge clk); #1;
            bus.rom_ack = 1'b0;
            if (rst_n && bus.rom_req && ($urandom_range(0, 3) != 0)) begin
                bus.rom_ack  = 1'b1;
                bus.rom_data = rom_byte(bus.rom_addr);
                ack_cnt++;
                if (rom_q.size() == 0) check("rom_unexpected", 32'd1, 32'd0);
                else check("rom_addr", bus.rom_addr, rom_q.pop_front());
            end
        end
    end

    // Fetch monitor: pops the scoreboard on every acknowledged fetch.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (bus.fetch_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_data", bus.fetch_data, e.data);
                    check("fetch_hit", bus.fetch_hit, e.hit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base_cnt;
        checks = 0; errors = 0; ack_cnt = 0;
        flags_m = 32'd0; cbr_m = 16'd0;
        bus.fetch_req = 1'b0; bus.fetch_addr = 16'd0;
        cbr_load = 1'b0; cbr_in = 16'd0;
        host_we = 1'b0; host_addr = 9'd0; host_di = 8'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_host_do", host_do, 32'd0);
        check("rst_rom_req", bus.rom_req, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cbr", cbr, 32'd0);
        check("rst_flags", valid_flags, 32'd0);
        check("rst_ack", bus.fetch_ack, 32'd0);
        check("rst_hit", bus.fetch_hit, 32'd0);
        check("rst_data", bus.fetch_data, 32'd0);
        check("rst_rom_addr", bus.rom_addr, 32'd0);
        check("rst_busy", busy, 32'd0);

        // Fill then hit inside window at 0x8000.
        load_cbr(16'h8003);
        check("cbr_aligned", cbr, 32'h8000);
        do_fetch(16'h8025, lat);
        check("fill_flags", valid_flags, 32'h4);
        do_fetch(16'h802A, lat);
        check("hit_latency", lat, 32'd2);

        // Window wrapping past 0xFFFF, then an out-of-window bypass.
        load_cbr(16'hFFF0);
        do_fetch(16'h0005, lat);
        check("wrap_flags", valid_flags, 32'h2);
        do_fetch(16'h01F0, lat);
        check("bypass_flags", valid_flags, flags_m);

        // Host writes: flag set only by the last byte of the line.
        for (int i = 0; i < 15; i++) host_write(9'h030 + 9'(i), 8'hC0 + 8'(i), 1'b1);
        check("host_flag_early", valid_flags, 32'h2);
        host_write(9'h03F, 8'hCF, 1'b1);
        check("host_flag_last", valid_flags, 32'hA);
        host_read(9'h030);
        do_fetch(16'hFFF0 + 16'h0034, lat);
        check("host_hit_latency", lat, 32'd2);

        // Host writes while busy are dropped.
        host_write(9'h100, 8'h11, 1'b1);
        base_cnt = ack_cnt;
        fork
            do_fetch(16'hFFF0 + 16'h0045, lat);
            begin
                wait_acks(base_cnt + 3);
                check("busy_in_fill", busy, 32'd1);
                host_write(9'h100, 8'h99, 1'b0);
                host_write(9'h1FF, 8'h77, 1'b0);
            end
        join
        host_read(9'h100);
        check("drop_flags", valid_flags, flags_m);

        // CBR load mid-fill: fill completes, flush lands on the next cycle.
        base_cnt = ack_cnt;
        fork
            do_fetch(16'hFFF0 + 16'h0063, lat);
            begin
                wait_acks(base_cnt + 3);
                cbr_load = 1'b1; cbr_in = 16'h1000;
                @(posedge clk); #1;
                cbr_load = 1'b0;
            end
        join
        check("pend_fill_flag", valid_flags[6], 32'd1);
        check("pend_cbr_old", cbr, 32'hFFF0);
        @(posedge clk); #1;
        check("pend_cbr_new", cbr, 32'h1000);
        check("pend_flags", valid_flags, 32'd0);
        cbr_m = 16'h1000; flags_m = 32'd0;

        // Reset in the middle of a fill.
        base_cnt = ack_cnt;
        for (int k = 0; k < 16; k++) rom_q.push_back(16'h1070 + 16'(k));
        bus.fetch_req = 1'b1; bus.fetch_addr = 16'h1077;
        wait_acks(base_cnt + 7);
        rst_n = 1'b0; bus.fetch_req = 1'b0;
        #1;
        check("mid_rst_rom_req", bus.rom_req, 32'd0);
        check("mid_rst_flags", valid_flags, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        rom_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        flags_m = 32'd0; cbr_m = 16'd0;
        load_cbr(16'h1000);
        base_cnt = ack_cnt;
        do_fetch(16'h1077, lat);
        check("refill_bytes", ack_cnt - base_cnt, 32'd16);
        do_fetch(16'h1070, lat);
        check("refill_hit_latency", lat, 32'd2);
        host_read(9'h07F);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("rom_q_empty", rom_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gsu_cache.md
# gsu_cache

Parametrised instruction cache for the GSU core: a power-of-two cache RAM windowed at a 16-bit cache base (CBR), with per-line valid flags, automatic line fill from Game Pak ROM on a miss, uncached pass-through for addresses outside the window, and a host (SNES CPU) port for direct cache RAM access. It sits between the GSU fetch stage and the ROM arbiter, replacing the fixed 512-byte cache array and flag vector embedded in the core.

## Interface
- LINE_W, 4: log2 bytes per line (LB = 2^LINE_W)
- IDX_W, 5: log2 number of lines (NL = 2^IDX_W); cache size CS = 2^(LINE_W+IDX_W) bytes, at most 32768
- clkin  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cbr_load  in  1  pulse: load CBR from cbr_in and clear all valid flags (GSU CACHE/LJMP)
- cbr_in  in  16  new CBR; bits [LINE_W-1:0] are forced to 0 on load
- cbr  out  16  current CBR
- fetch_req  in  1  core fetch request, held until fetch_ack
- fetch_addr  in  16  PC to fetch, stable while fetch_req
- fetch_ack  out  1  one-cycle pulse, fetch_data valid
- fetch_data  out  8  fetched byte
- fetch_hit  out  1  qualifies fetch_ack: 1 = served from cache without fill
- busy  out  1  state != IDLE
- rom_req  out  1  ROM byte read request
- rom_addr  out  16  ROM address (bank supplied externally)
- rom_ack  in  1  one-cycle pulse, rom_data valid same cycle
- rom_data  in  8  ROM byte
- host_we  in  1  host write strobe (one cycle per write)
- host_addr  in  IDX_W+LINE_W  host offset into cache RAM
- host_di  in  8  host write data
- host_do  out  8  host read data
- valid_flags  out  NL  per-line valid flags

## Operation
- Window: off = fetch_addr - cbr (16-bit, wraps); in-window iff off < CS. Cache index = off[IDX_W+LINE_W-1:0]; line = off[IDX_W+LINE_W-1:LINE_W].
- States: IDLE, HIT, FILL, BYPASS.
- IDLE: pending flush first (see below); else on fetch_req: in-window and valid_flags[line] -> HIT; in-window and invalid -> FILL; out-of-window -> BYPASS.
- HIT: read RAM[index]; drive fetch_data, fetch_ack=1, fetch_hit=1; -> IDLE.
- FILL: rom_addr = cbr + (line<<LINE_W) + k, k = 0..LB-1, 16-bit wrap. rom_req high throughout; each rom_ack writes rom_data to RAM[line*LB+k] and advances k. After byte LB-1: set valid_flags[line], rom_req=0, return the requested byte (captured when k matched, not re-read) with fetch_ack=1, fetch_hit=0; -> IDLE.
- BYPASS: rom_addr = fetch_addr, rom_req until rom_ack; fetch_data = rom_data, fetch_ack=1, fetch_hit=0; no RAM or flag change; -> IDLE.
- cbr_load: in IDLE, applied immediately (priority over fetch_req that cycle). While busy, latched as pending (last cbr_in wins) and applied on the IDLE cycle after the current fetch completes; the in-flight fill still completes and sets its flag, which the flush then clears.
- Host write: when !busy, RAM[host_addr] = host_di; if host_addr[LINE_W-1:0] == LB-1, set valid_flags[host_addr line]. Host writes while busy are dropped (no RAM/flag change).
- Host read: host_do = RAM[host_addr], independent of state (second RAM port).
- Same-cycle host write and cbr_load in IDLE: flags cleared, then the host write's flag set applies (write flag set wins).

## Timing
- Reset: state IDLE, cbr=0, valid_flags=0, fetch_ack=0, fetch_hit=0, fetch_data=0, rom_req=0, rom_addr=0, host_do=0, busy=0, no pending flush. Reset mid-fill aborts with no flag set.
- All outputs registered.
- Hit latency: fetch_req sampled at edge N -> fetch_ack high after edge N+1 for one cycle. Core may hold fetch_req with a new address immediately; next sample at edge N+2 (one fetch per 2 cycles).
- Fill: rom_req rises after edge N; one byte per rom_ack; fetch_ack one cycle after the edge that samples the last rom_ack.
- Bypass: fetch_ack one cycle after the edge sampling rom_ack.
- rom_addr changes only on the edge that samples rom_ack; rom_ack while rom_req=0 is ignored.
- cbr_load in IDLE: cbr and cleared flags visible after the next edge.
- Host read latency 1 cycle.

## Test plan
- Reset then idle: all outputs 0; host read of any offset after reset returns whatever RAM holds, flags all 0.
- LINE_W=4, IDX_W=5, cbr_load 0x8003 -> cbr=0x8000; fetch 0x8025: fill rom_addr 0x8020..0x802F, byte 5 = 0xA5 -> fetch_data 0xA5, fetch_hit=0, valid_flags=0x4; refetch 0x802A -> hit, ack 2 cycles after req.
- cbr=0xFFF0, fetch 0x0005 -> off 0x15, fill rom_addr 0x0000..0x000F (wrap), flag[1] set; fetch 0x01F0 (off 0x200) -> BYPASS, single ROM read, flags unchanged.
- Host writes offsets 0x30..0x3F (0x3F last) -> valid_flags[3]=1 only after 0x3F; fetch cbr+0x34 hits with written byte; host write during fill dropped.
- cbr_load 0x1000 mid-fill: fill completes with correct ack, then cbr=0x1000, flags 0 before next fetch accepted.
- Assert rst_n low at fill byte 7: rom_req=0, flags 0 immediately; after release a fetch to same line refills all 16 bytes.
